alu_muldiv_ctrl: RTL

- Multi-cycle sequencer that runs 32x32 unsigned multiply and unsigned divide on the shared 32-bit combinational ALU (8-bit-slice ALU with cout, g, e).
- Drives the ALU operand, carry and select inputs one step per clock and consumes its out/cout/g/e results.
- Sits beside the ALU in the execute stage and produces MIPS-style HI/LO results with a start/busy/done handshake.

---
 rtl/alu_muldiv_ctrl_pkg.sv | 20 ++
 rtl/alu_muldiv_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: ALU select codes,
// FSM state encodings and the op field meaning.
package alu_muldiv_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [4:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_muldiv_ctrl.sv
// Multi-cycle 32x32 unsigned multiply / restoring divide sequencer that
// borrows the shared execute-stage ALU one step per clock.
//
// state | meaning
// IDLE  | waiting for start; ALU interface parked at 0 + 0
// MUL   | shift-add step: {P_hi,P_lo} += M when P_lo[0], then shift right
// DIV   | restoring step: shift {R,Q} left, subtract D when it fits
// DONE  | one-cycle done pulse, hi/lo/div_by_zero valid
module alu_muldiv_ctrl
    import alu_muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic [2:0]  alu_s,
    input  logic [31:0] alu_out,
    input  logic        alu_cout,
    input  logic        alu_g,
    input  logic        alu_e
);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] opnd;      // M for multiply, D for divide
    logic [31:0] acc_hi;    // P_hi / R
    logic [31:0] acc_lo;    // P_lo / Q
    logic [31:0] nxt_hi, nxt_lo;
    logic [31:0] div_s;
    logic        div_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        alu_s     = OP_ADD;
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        div_s     = {acc_hi[30:0], acc_lo[31]};
        // A set R[31] means the shifted remainder is a 33-bit value above D.
        div_take  = acc_hi[31] | alu_g | alu_e;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL)    state_nxt = MUL;
                    else if (opb == '0)  state_nxt = DONE;
                    else                 state_nxt = DIV;
                end
            end
            MUL: begin
                alu_a  = acc_hi;
                alu_b  = acc_lo[0] ? opnd : '0;
                nxt_hi = {alu_cout, alu_out[31:1]};
                nxt_lo = {alu_out[0], acc_lo[31:1]};
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DIV: begin
                alu_a   = div_s;
                alu_b   = opnd;
                alu_cin = 1'b1;
                alu_s   = OP_SUB;
                if (div_take) begin
                    nxt_hi = alu_out;
                    nxt_lo = {acc_lo[30:0], 1'b1};
                end else begin
                    nxt_hi = div_s;
                    nxt_lo = {acc_lo[30:0], 1'b0};
                end
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc_hi <= '0;
                        if (op == OP_MUL) begin
                            opnd   <= opa;
                            acc_lo <= opb;
                        end else if (opb != '0) begin
                            opnd   <= opb;
                            acc_lo <= opa;
                        end else begin
                            hi          <= opa;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 5'd1;
                    // Commit uses the final step's values, not the stale bank.
                    if (cnt == CNT_LAST) begin
                        hi          <= nxt_hi;
                        lo          <= nxt_lo;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
